// File: rtl/pc_branch_unit.sv
// PC, flag register and branch resolution for the miniRISC EX stage.
// Optional build macro FLAG_BYPASS_EN: branches see same-cycle ALU flags.
module pc_branch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            flag_we,
  input  logic            fzero,
  input  logic            fsign,
  input  logic            fcarry,
  input  logic            br_en,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt_in,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            flush,
  output logic            link_we,
  output logic [PC_W-1:0] link_data,
  output logic [2:0]      flags_q,
  output logic            halted
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

  localparam logic [PC_W-1:0] FOUR  = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  state_e          state;
  logic            go;
  logic            taken;
  logic [2:0]      eflags;
  logic [PC_W-1:0] target;

  assign go        = ex_valid & ~stall & (state == RUN);
  assign pc_plus4  = pc + FOUR;
  assign link_data = ex_pc + FOUR;
  assign link_we   = ~rst & go & br_en & (br_cond == 3'b100) & ~halt_in;
  assign target    = br_target & ALIGN;

`ifdef FLAG_BYPASS_EN
  assign eflags = (flag_we & go) ? {fzero, fsign, fcarry} : flags_q;
`else
  assign eflags = flags_q;
`endif

  // eflags is {Z,S,C}
  always_comb begin
    taken = 1'b0;
    case (br_cond)
      3'b000, 3'b100: taken = 1'b1;
      3'b001:         taken = eflags[1];
      3'b010:         taken = eflags[2];
      3'b011:         taken = ~eflags[2];
      3'b101:         taken = eflags[0];
      3'b110:         taken = ~eflags[0];
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      flags_q <= 3'b000;
      flush   <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flag_we & go) flags_q <= {fzero, fsign, fcarry};
          if (halt_in & go) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (br_en & taken & go) begin
            pc    <= target;
            state <= FLUSH;
            flush <= 1'b1;
          end else if (!stall) begin
            pc <= pc_plus4;
          end
        end
        // Stall keeps the bubble marked until the fetch actually advances
        FLUSH: begin
          if (!stall) begin
            pc    <= pc_plus4;
            state <= RUN;
            flush <= 1'b0;
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed scoreboard bench for pc_branch_unit (PC_W=32, RESET_PC=0).
module tb_pc_branch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, flag_we, fzero, fsign, fcarry;
  logic        br_en, halt_in;
  logic [2:0]  br_cond;
  logic [31:0] ex_pc, br_target;
  logic [31:0] pc, pc_plus4, link_data;
  logic        flush, link_we, halted;
  logic [2:0]  flags_q;

  pc_branch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .flag_we(flag_we), .fzero(fzero), .fsign(fsign), .fcarry(fcarry),
    .br_en(br_en), .br_cond(br_cond), .br_target(br_target), .halt_in(halt_in),
    .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .link_we(link_we),
    .link_data(link_data), .flags_q(flags_q), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef enum {S_PC, S_PC4, S_FLUSH, S_LWE, S_LDATA, S_FLAGS, S_HALTED} sig_e;
  typedef struct { sig_e sig; logic [31:0] exp; } item_t;
  item_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_PC:    return pc;
      S_PC4:   return pc_plus4;
      S_FLUSH: return {31'b0, flush};
      S_LWE:   return {31'b0, link_we};
      S_LDATA: return link_data;
      S_FLAGS: return {29'b0, flags_q};
      default: return {31'b0, halted};
    endcase
  endfunction

  task automatic exp_v(sig_e s, logic [31:0] v);
    sb.push_back('{s, v});
  endtask

  task automatic check();
    item_t e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.sig);
      vectors++;
      assert (a === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.sig.name(), a, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic comb();
    #1;
    check();
  endtask

  task automatic drive(logic v, logic b, logic [2:0] c, logic [31:0] t);
    ex_valid = v; br_en = b; br_cond = c; br_target = t;
  endtask

  task automatic pc_fl(logic [31:0] p, logic f);
    exp_v(S_PC, p); exp_v(S_FLUSH, {31'b0, f});
  endtask

  logic [31:0] b;

  initial begin
    rst = 1'b1; stall = 1'b0; flag_we = 1'b0; fzero = 1'b0; fsign = 1'b0;
    fcarry = 1'b0; halt_in = 1'b0; ex_pc = 32'h0;
    drive(1'b1, 1'b1, 3'b100, 32'h0);
    // Reset state; link_we suppressed while rst is high
    pc_fl(32'h0, 1'b0); exp_v(S_FLAGS, 0); exp_v(S_HALTED, 0); exp_v(S_LWE, 0);
    comb();
    drive(1'b0, 1'b0, 3'b000, 32'h0);
    #11 rst = 1'b0;

    // Sequential fetch
    drive(1'b1, 1'b0, 3'b000, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      pc_fl(32'(4 * i), 1'b0);
      cyc();
    end
    exp_v(S_PC4, 32'h14); comb();

    // Flag capture {Z,S,C}=101
    flag_we = 1'b1; fzero = 1'b1; fsign = 1'b0; fcarry = 1'b1;
    exp_v(S_PC, 32'h14); exp_v(S_FLAGS, 3'b101); cyc();
    flag_we = 1'b0;

    // bz taken, target aligned
    drive(1'b1, 1'b1, 3'b010, 32'h103);
    exp_v(S_LWE, 0); comb();
    pc_fl(32'h100, 1'b1); cyc();
    // FLUSH cycle ignores EX: bl and flag_we have no effect
    drive(1'b1, 1'b1, 3'b100, 32'h999);
    flag_we = 1'b1; fzero = 1'b0; fsign = 1'b0; fcarry = 1'b0;
    exp_v(S_LWE, 0); comb();
    pc_fl(32'h104, 1'b0); exp_v(S_FLAGS, 3'b101); cyc();
    flag_we = 1'b0;

    // Stall while in FLUSH holds pc and flush
    drive(1'b1, 1'b1, 3'b000, 32'h200);
    pc_fl(32'h200, 1'b1); cyc();
    drive(1'b1, 1'b0, 3'b000, 32'h0); stall = 1'b1;
    pc_fl(32'h200, 1'b1); cyc();
    stall = 1'b0;
    pc_fl(32'h204, 1'b0); cyc();

    // bl link
    ex_pc = 32'h40; drive(1'b1, 1'b1, 3'b100, 32'h80);
    exp_v(S_LWE, 1); exp_v(S_LDATA, 32'h44); comb();
    pc_fl(32'h80, 1'b1); cyc();
    drive(1'b1, 1'b0, 3'b000, 32'h0);
    pc_fl(32'h84, 1'b0); cyc();

    // Flags Z=0,S=1,C=0
    flag_we = 1'b1; fzero = 1'b0; fsign = 1'b1; fcarry = 1'b0;
    exp_v(S_PC, 32'h88); exp_v(S_FLAGS, 3'b010); cyc();

    // bnz with same-cycle flag write Z=1
    fzero = 1'b1; fsign = 1'b0; fcarry = 1'b0;
    drive(1'b1, 1'b1, 3'b011, 32'h300);
`ifdef FLAG_BYPASS_EN
    pc_fl(32'h8C, 1'b0); b = 32'h90;
`else
    pc_fl(32'h300, 1'b1); b = 32'h304;
`endif
    exp_v(S_FLAGS, 3'b100); cyc();
    flag_we = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 32'h0);
    pc_fl(b, 1'b0); cyc();

    // Flags now Z=1,S=0,C=0: bltz not taken, bncy taken, never, bcy not taken
    drive(1'b1, 1'b1, 3'b001, 32'h900);
    pc_fl(b + 32'h4, 1'b0); cyc();
    drive(1'b1, 1'b1, 3'b110, 32'h404);
    pc_fl(32'h404, 1'b1); cyc();
    drive(1'b1, 1'b0, 3'b000, 32'h0);
    pc_fl(32'h408, 1'b0); cyc();
    drive(1'b1, 1'b1, 3'b111, 32'h500);
    pc_fl(32'h40C, 1'b0); cyc();
    drive(1'b1, 1'b1, 3'b101, 32'h500);
    pc_fl(32'h410, 1'b0); cyc();

    // Wrap of pc+4 and ex_pc+4
    ex_pc = 32'hFFFF_FFFC; drive(1'b1, 1'b1, 3'b000, 32'hFFFF_FFFF);
    exp_v(S_LDATA, 32'h0); comb();
    pc_fl(32'hFFFF_FFFC, 1'b1); exp_v(S_PC4, 32'h0); cyc();
    drive(1'b1, 1'b0, 3'b000, 32'h0);
    pc_fl(32'h0, 1'b0); cyc();

    // Async reset mid-cycle while in FLUSH
    drive(1'b1, 1'b1, 3'b000, 32'h600);
    pc_fl(32'h600, 1'b1); exp_v(S_FLAGS, 3'b100); cyc();
    #2 rst = 1'b1;
    pc_fl(32'h0, 1'b0); exp_v(S_FLAGS, 0); comb();
    stall = 1'b1; drive(1'b1, 1'b1, 3'b000, 32'h700);
    rst = 1'b0;

    // Stall-held branch waits for stall to drop
    pc_fl(32'h0, 1'b0); cyc();
    stall = 1'b0;
    pc_fl(32'h700, 1'b1); cyc();
    drive(1'b1, 1'b0, 3'b000, 32'h0);
    pc_fl(32'h704, 1'b0); cyc();

    // Halt beats branch in the same cycle
    halt_in = 1'b1; drive(1'b1, 1'b1, 3'b100, 32'h800);
    exp_v(S_LWE, 0); comb();
    pc_fl(32'h704, 1'b0); exp_v(S_HALTED, 1); cyc();
    halt_in = 1'b0; flag_we = 1'b1; fzero = 1'b1;
    drive(1'b1, 1'b1, 3'b000, 32'h800);
    pc_fl(32'h704, 1'b0); exp_v(S_HALTED, 1); exp_v(S_FLAGS, 0); cyc();

    // Only reset leaves HALT
    #2 rst = 1'b1;
    exp_v(S_HALTED, 0); exp_v(S_PC, 32'h0); comb();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
